// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types for the unified memory arbiter: FSM states, grant encoding,
// default bus widths and the fixed-priority arbitration rule.
package unified_mem_arbiter_pkg;

  localparam int AW_DEF = 32;
  localparam int DW_DEF = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2,
    RESP    = 2'd3
  } arbState_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_DM   = 2'd2
  } grant_t;

  // Data access has priority; a starved fetch overrides it.
  function automatic grant_t arbitrate(input logic ifElig, input logic dmElig,
                                       input logic starved);
    grant_t g;
    g = GNT_NONE;
    if (ifElig && (!dmElig || starved)) g = GNT_IF;
    else if (dmElig)                    g = GNT_DM;
    return g;
  endfunction

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Bundle of the fetch, data and memory-side handshakes around the arbiter.
// slave = arbiter view, master = requesters plus memory model view.
interface unified_mem_arbiter_if
  import unified_mem_arbiter_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) ();

  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ack;

  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dm_ack;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_done;

  logic          stall;
  logic          err;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_done,
    output if_rdata, if_ack, dm_rdata, dm_ack, mem_req, mem_we, mem_addr, mem_wdata,
           stall, err
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_done,
    input  if_rdata, if_ack, dm_rdata, dm_ack, mem_req, mem_we, mem_addr, mem_wdata,
           stall, err
  );

endinterface

// File: rtl/unified_mem_arbiter_watchdog.sv
// Counts cycles an access has spent waiting on memory and flags the cycle in
// which the wait reaches TIMEOUT so the arbiter can abort it.
module mem_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wdCnt;

  always_ff @(posedge clk) begin
    if (rst || clr)
      wdCnt <= '0;
    else if (en && (wdCnt != CW'(TIMEOUT - 1)))
      wdCnt <= wdCnt + CW'(1);
  end

  // Fires on the TIMEOUT-th waiting cycle, counting the first as zero.
  assign timeout = en && (wdCnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-ported memory arbiter between instruction fetch and load/store:
// arbitration with starvation override, registered memory handshake, ack pulse, stall.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input logic                  clk,
  input logic                  rst,
  unified_mem_arbiter_if.slave bus
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  arbState_t     state, stateNext;
  grant_t        grant;
  logic          memReqR, memWeR;
  logic [AW-1:0] memAddrR;
  logic [DW-1:0] memWdataR, ifRdataR, dmRdataR;
  logic          ifAckR, dmAckR, errR;
  logic [SW-1:0] starveCnt;
  logic          arbitrating, busy, memDone, timeout, accessEnd;
  logic          ifElig, dmElig, starved;

  assign arbitrating = (state == IDLE) || (state == RESP);
  assign busy        = (state == BUSY_IF) || (state == BUSY_DM);
  assign memDone     = busy && bus.mem_done;
  assign accessEnd   = memDone || timeout;

  // The ack registers are high only in RESP, so they mask the requester just served.
  assign ifElig  = bus.if_req && !ifAckR;
  assign dmElig  = bus.dm_req && !dmAckR;
  assign starved = (starveCnt == SW'(STARVE_MAX));
  assign grant   = arbitrating ? arbitrate(ifElig, dmElig, starved) : GNT_NONE;

  mem_watchdog #(.TIMEOUT(TIMEOUT)) watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (grant != GNT_NONE),
    .en      (busy && !bus.mem_done),
    .timeout (timeout)
  );

  always_comb begin
    stateNext = state;
    case (state)
      IDLE, RESP: begin
        case (grant)
          GNT_IF:  stateNext = BUSY_IF;
          GNT_DM:  stateNext = BUSY_DM;
          default: stateNext = IDLE;
        endcase
      end
      BUSY_IF, BUSY_DM: begin
        if (accessEnd) stateNext = RESP;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      memReqR   <= 1'b0;
      memWeR    <= 1'b0;
      memAddrR  <= '0;
      memWdataR <= '0;
      ifRdataR  <= '0;
      dmRdataR  <= '0;
      ifAckR    <= 1'b0;
      dmAckR    <= 1'b0;
      errR      <= 1'b0;
      starveCnt <= '0;
    end else begin
      state  <= stateNext;
      ifAckR <= 1'b0;
      dmAckR <= 1'b0;

      if (grant == GNT_IF) begin
        memReqR   <= 1'b1;
        memWeR    <= 1'b0;
        memAddrR  <= bus.if_addr;
        memWdataR <= '0;
        starveCnt <= '0;
      end else if (grant == GNT_DM) begin
        memReqR   <= 1'b1;
        memWeR    <= bus.dm_we;
        memAddrR  <= bus.dm_addr;
        memWdataR <= bus.dm_wdata;
        if (bus.if_req && !starved) starveCnt <= starveCnt + SW'(1);
      end

      // An aborted access still acks, returning zero for reads.
      if (busy && accessEnd) begin
        memReqR <= 1'b0;
        if (timeout) errR <= 1'b1;
        if (state == BUSY_IF) begin
          ifAckR   <= 1'b1;
          ifRdataR <= memDone ? bus.mem_rdata : '0;
        end else begin
          dmAckR <= 1'b1;
          if (!memWeR) dmRdataR <= memDone ? bus.mem_rdata : '0;
        end
      end
    end
  end

  assign bus.mem_req   = memReqR;
  assign bus.mem_we    = memWeR;
  assign bus.mem_addr  = memAddrR;
  assign bus.mem_wdata = memWdataR;
  assign bus.if_rdata  = ifRdataR;
  assign bus.if_ack    = ifAckR;
  assign bus.dm_rdata  = dmRdataR;
  assign bus.dm_ack    = dmAckR;
  assign bus.err       = errR;
  assign bus.stall     = (bus.if_req && !ifAckR) || (bus.dm_req && !dmAckR);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed scenarios with literal expectations,
// then random traffic, all compared every cycle against a transaction-level model.
module tb_unified_mem_arbiter;

  localparam int AW = 32, DW = 32, SMAX = 4, TMO = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  unified_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  unified_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SMAX), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Expected outputs after each edge, plus the model's view of the current access.
  logic        eReq = 0, eWe = 0, eIfAck = 0, eDmAck = 0, eErr = 0;
  logic [31:0] eAddr = 0, eWdata = 0, eIfRd = 0, eDmRd = 0;
  int          owner = 0;    // 0 none, 1 fetch, 2 data
  int          waited = 0;   // cycles the current access has waited on memory
  int          starve = 0;

  // Memory responder state.
  bit          memRand = 0, memMute = 0, memActive = 0;
  int          memK = 0, memCnt = 0;
  logic [31:0] memData = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic        ifE, dmE, nIfAck, nDmAck;
    logic [31:0] d;
    nIfAck = 0;
    nDmAck = 0;
    if (rst) begin
      eReq = 0; eWe = 0; eAddr = 0; eWdata = 0; eIfRd = 0; eDmRd = 0; eErr = 0;
      owner = 0; waited = 0; starve = 0;
    end else if (owner != 0) begin
      if (bus.mem_done || waited == TMO - 1) begin
        d = bus.mem_done ? bus.mem_rdata : 32'h0;
        if (!bus.mem_done) eErr = 1;
        eReq = 0;
        if (owner == 1) begin eIfRd = d; nIfAck = 1; end
        else begin if (!eWe) eDmRd = d; nDmAck = 1; end
        owner = 0;
      end else begin
        waited++;
      end
    end else begin
      ifE = bus.if_req && !eIfAck;
      dmE = bus.dm_req && !eDmAck;
      if (ifE && (!dmE || starve == SMAX)) begin
        owner = 1; eReq = 1; eWe = 0; eAddr = bus.if_addr; eWdata = 0;
        waited = 0; starve = 0;
      end else if (dmE) begin
        owner = 2; eReq = 1; eWe = bus.dm_we; eAddr = bus.dm_addr; eWdata = bus.dm_wdata;
        waited = 0;
        if (bus.if_req && starve < SMAX) starve++;
      end
    end
    eIfAck = nIfAck;
    eDmAck = nDmAck;
  endtask

  task automatic compare_all();
    chk("mem_req",   bus.mem_req,   eReq);
    chk("mem_we",    bus.mem_we,    eWe);
    chk("mem_addr",  bus.mem_addr,  eAddr);
    chk("mem_wdata", bus.mem_wdata, eWdata);
    chk("if_ack",    bus.if_ack,    eIfAck);
    chk("dm_ack",    bus.dm_ack,    eDmAck);
    chk("if_rdata",  bus.if_rdata,  eIfRd);
    chk("dm_rdata",  bus.dm_rdata,  eDmRd);
    chk("err",       bus.err,       eErr);
  endtask

  // Inputs for the coming edge are already driven when this is called.
  task automatic tick();
    #1;
    chk("stall", bus.stall, (bus.if_req && !eIfAck) || (bus.dm_req && !eDmAck));
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic drive_mem();
    bus.mem_done  = 1'b0;
    bus.mem_rdata = $urandom;
    if (eReq) begin
      if (!memActive) begin
        memActive = 1;
        memCnt    = memK;
        if (memRand) begin
          memCnt  = $urandom_range(0, 3);
          memMute = ($urandom_range(0, 59) == 0);
        end
      end
      if (!memMute && memCnt == 0) begin
        bus.mem_done  = 1'b1;
        bus.mem_rdata = memRand ? $urandom : memData;
        memActive     = 0;
      end else if (memCnt > 0) begin
        memCnt--;
      end
    end else begin
      memActive = 0;
      if (memRand && $urandom_range(0, 7) == 0) bus.mem_done = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    bus.if_req = 0;
    bus.dm_req = 0;
    for (int i = 0; i < n; i++) begin
      drive_mem();
      tick();
    end
  endtask

  initial begin
    int  cnt, acks;
    bit  ifActive, dmActive;

    rst = 1;
    bus.if_req = 0; bus.if_addr = 0; bus.dm_req = 0; bus.dm_we = 0;
    bus.dm_addr = 0; bus.dm_wdata = 0; bus.mem_rdata = 0; bus.mem_done = 0;
    tick();
    tick();
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_if_rdata", bus.if_rdata, 0);
    rst = 0;
    idle(2);

    // Single fetch, memory answers two cycles after the request appears.
    memK = 2; memData = 32'h8C01_0004;
    bus.if_req = 1; bus.if_addr = 32'h40;
    #1 chk("t1_stall_N", bus.stall, 1);
    drive_mem();
    tick();
    chk("t1_mem_req", bus.mem_req, 1);
    chk("t1_mem_addr", bus.mem_addr, 32'h40);
    for (int i = 0; i < 3; i++) begin
      chk("t1_stall_wait", bus.stall, 1);
      drive_mem();
      tick();
    end
    chk("t1_if_ack", bus.if_ack, 1);
    chk("t1_if_rdata", bus.if_rdata, 32'h8C01_0004);
    chk("t1_stall_ack", bus.stall, 0);
    idle(2);

    // Simultaneous fetch and load: data first, fetch granted straight from RESP.
    memK = 0; memData = 32'h1234_5678;
    bus.if_req = 1; bus.if_addr = 32'h44;
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h100;
    drive_mem(); tick();
    chk("t2_dm_first", bus.mem_addr, 32'h100);
    drive_mem(); tick();
    chk("t2_dm_ack", bus.dm_ack, 1);
    chk("t2_dm_rdata", bus.dm_rdata, 32'h1234_5678);
    bus.dm_req = 0;
    memData = 32'h0BAD_F00D;
    drive_mem(); tick();
    chk("t2_if_no_bubble", bus.mem_req, 1);
    chk("t2_if_addr", bus.mem_addr, 32'h44);
    drive_mem(); tick();
    chk("t2_if_ack", bus.if_ack, 1);
    chk("t2_if_rdata", bus.if_rdata, 32'h0BAD_F00D);
    idle(2);

    // Store with zero-cycle memory; load data register must not move.
    memData = 32'h5555_5555;
    bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 32'h200; bus.dm_wdata = 32'hDEAD_BEEF;
    drive_mem(); tick();
    chk("t4_mem_we", bus.mem_we, 1);
    chk("t4_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    chk("t4_mem_addr", bus.mem_addr, 32'h200);
    drive_mem(); tick();
    chk("t4_dm_ack", bus.dm_ack, 1);
    chk("t4_dm_rdata_kept", bus.dm_rdata, 32'h1234_5678);
    idle(2);

    // Fetch loses four contested arbitrations, then wins the fifth.
    for (int i = 0; i < 5; i++) begin
      bus.if_req = 1; bus.if_addr = 32'h600;
      bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h300 + 32'(4 * i);
      drive_mem(); tick();
      if (i < 4) begin
        chk("t3_dm_wins", bus.mem_addr, 32'h300 + 32'(4 * i));
        bus.if_req = 0;
        drive_mem(); tick();
        chk("t3_dm_ack", bus.dm_ack, 1);
        bus.dm_req = 0;
        drive_mem(); tick();
      end else begin
        chk("t3_if_wins", bus.mem_addr, 32'h600);
      end
    end
    acks = 0;
    for (int c = 0; c < 12 && (bus.if_req || bus.dm_req); c++) begin
      drive_mem(); tick();
      if (bus.if_ack) begin bus.if_req = 0; acks++; end
      if (bus.dm_ack) begin bus.dm_req = 0; acks++; end
    end
    chk("t3_drain_acks", acks, 2);
    idle(2);

    // Memory never answers: abort after TIMEOUT waiting cycles.
    memMute = 1;
    bus.if_req = 1; bus.if_addr = 32'h80;
    drive_mem(); tick();
    cnt = 0;
    while (bus.mem_req && cnt < 200) begin
      cnt++;
      drive_mem(); tick();
    end
    chk("t5_busy_cycles", cnt, TMO);
    chk("t5_if_ack", bus.if_ack, 1);
    chk("t5_if_rdata", bus.if_rdata, 0);
    chk("t5_err", bus.err, 1);
    memMute = 0;
    idle(3);
    chk("t5_err_sticky", bus.err, 1);

    // Reset during a data access, then a stray completion.
    memMute = 1;
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h400;
    drive_mem(); tick();
    drive_mem(); tick();
    chk("t6_busy", bus.mem_req, 1);
    rst = 1;
    drive_mem(); tick();
    chk("t6_rst_mem_req", bus.mem_req, 0);
    chk("t6_rst_mem_addr", bus.mem_addr, 0);
    chk("t6_rst_err", bus.err, 0);
    chk("t6_rst_dm_rdata", bus.dm_rdata, 0);
    rst = 0; bus.dm_req = 0; memMute = 0;
    bus.mem_done = 1; bus.mem_rdata = 32'hFFFF_FFFF;
    tick();
    chk("t6_late_done_req", bus.mem_req, 0);
    chk("t6_late_done_ack", bus.dm_ack, 0);
    idle(2);

    // Random traffic, including early request drops, stray completions and resets.
    memRand = 1;
    ifActive = 0;
    dmActive = 0;
    for (int c = 0; c < 3000; c++) begin
      if (eIfAck) ifActive = 0;
      if (eDmAck) dmActive = 0;
      if (ifActive && $urandom_range(0, 49) == 0) ifActive = 0;
      if (dmActive && $urandom_range(0, 49) == 0) dmActive = 0;
      if (!ifActive && $urandom_range(0, 2) == 0) begin
        ifActive = 1; bus.if_addr = $urandom;
      end
      if (!dmActive && $urandom_range(0, 2) == 0) begin
        dmActive = 1; bus.dm_addr = $urandom; bus.dm_wdata = $urandom;
        bus.dm_we = 1'($urandom_range(0, 1));
      end
      rst = ($urandom_range(0, 399) == 0);
      if (rst) begin ifActive = 0; dmActive = 0; end
      bus.if_req = ifActive;
      bus.dm_req = dmActive;
      drive_mem();
      tick();
    end
    rst = 0;
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
